// File: rtl/silife_matrix_wb_bridge_if.sv
// Wishbone classic slave bundle for the SiLife matrix bridge.
interface silife_matrix_wb_bridge_if;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic        i_wb_we;
  logic [3:0]  i_wb_sel;
  logic [31:0] i_wb_addr;
  logic [31:0] i_wb_data;
  logic        o_wb_ack;
  logic [31:0] o_wb_data;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_sel, i_wb_addr, i_wb_data,
    input  o_wb_ack, o_wb_data
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_sel, i_wb_addr, i_wb_data,
    output o_wb_ack, o_wb_data
  );
endinterface

// File: rtl/silife_matrix_wb_bridge.sv
// Wishbone row-level access to the SiLife cell matrix, with a bulk
// fill/clear engine that sweeps one row per cycle.
module silife_matrix_wb_bridge #(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 32,
  localparam int ROW_BITS = $clog2(HEIGHT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    cells,
  output logic [ROW_BITS-1:0] row_select,
  output logic [WIDTH-1:0]    set_cells,
  output logic [WIDTH-1:0]    clear_cells,
  output logic                busy,
  silife_matrix_wb_bridge_if.slave wb
);
  localparam int WPR       = (WIDTH + 31) / 32;
  localparam int WORD_BITS = (WPR > 1) ? $clog2(WPR) : 0;

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q, state_d;
  logic [ROW_BITS-1:0] cnt_q, cnt_d;
  logic                last_q, last_d;
  logic                ack_q, ack_d;
  logic [31:0]         rdata_q, rdata_d;

  logic [31:0]      word_idx, row_idx;
  logic [1:0]       mode;
  logic             req, ctrl_acc, row_acc, in_range;
  logic [31:0]      bmask, rd_word, ctrl_word;
  logic [WIDTH-1:0] m_w, d_w;

  // Address decode, byte-lane mask placement and row word extraction.
  always_comb begin
    word_idx  = (wb.i_wb_addr >> 2) & ((32'd1 << WORD_BITS) - 32'd1);
    row_idx   = (wb.i_wb_addr >> (2 + WORD_BITS)) & ((32'd1 << ROW_BITS) - 32'd1);
    mode      = wb.i_wb_addr[13:12];
    in_range  = (word_idx < 32'(WPR)) && (row_idx < 32'(HEIGHT));
    busy      = (state_q == RUN);
    req       = wb.i_wb_cyc & wb.i_wb_stb & ~ack_q & ~reset;
    ctrl_acc  = req & wb.i_wb_addr[14];
    row_acc   = req & ~wb.i_wb_addr[14] & ~busy;
    bmask     = {{8{wb.i_wb_sel[3]}}, {8{wb.i_wb_sel[2]}},
                 {8{wb.i_wb_sel[1]}}, {8{wb.i_wb_sel[0]}}};
    ctrl_word = {16'b0, 8'(cnt_q), 6'b0, last_q, busy};
    m_w       = '0;
    d_w       = '0;
    rd_word   = '0;
    for (int b = 0; b < WIDTH; b++) begin
      if (word_idx == 32'(b / 32)) begin
        m_w[b]            = bmask[b % 32];
        d_w[b]            = wb.i_wb_data[b % 32];
        rd_word[b % 32]   = cells[b];
      end
    end
  end

  // Bulk FSM next state, control register and registered bus response.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    ack_d   = ctrl_acc | row_acc;
    rdata_d = '0;
    if (row_acc && !wb.i_wb_we && in_range) rdata_d = rd_word;
    if (ctrl_acc && !wb.i_wb_we)            rdata_d = ctrl_word;
    case (state_q)
      IDLE: begin
        if (ctrl_acc && wb.i_wb_we) begin
          last_d = wb.i_wb_data[1];
          if (wb.i_wb_data[0]) begin
            state_d = RUN;
            cnt_d   = '0;
          end
        end
      end
      RUN: begin
        if (cnt_q == ROW_BITS'(HEIGHT - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Matrix-side outputs: bulk sweep in RUN, mode-dependent strobes on a write accept.
  always_comb begin
    set_cells   = '0;
    clear_cells = '0;
    row_select  = row_idx[ROW_BITS-1:0];
    if (busy) begin
      row_select  = cnt_q;
      set_cells   = {WIDTH{last_q}};
      clear_cells = {WIDTH{~last_q}};
    end else if (row_acc && wb.i_wb_we && in_range) begin
      case (mode)
        2'b00: begin
          set_cells   = m_w & d_w;
          clear_cells = m_w & ~d_w;
        end
        2'b01: set_cells   = m_w & d_w;
        2'b10: clear_cells = m_w & d_w;
        default: begin
          set_cells   = m_w & d_w & ~cells;
          clear_cells = m_w & d_w & cells;
        end
      endcase
    end
  end

  // State and bus response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  assign wb.o_wb_ack  = ack_q;
  assign wb.o_wb_data = rdata_q;
endmodule

// File: tb/tb_silife_matrix_wb_bridge.sv
// Self-checking bench: a 64x32 bridge and an 80x33 bridge for ragged edges.
module tb_silife_matrix_wb_bridge;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  silife_matrix_wb_bridge_if bus_a ();
  silife_matrix_wb_bridge_if bus_b ();

  logic [63:0] cells_a, set_a, clr_a;
  logic [4:0]  rs_a;
  logic        busy_a;
  logic [79:0] cells_b, set_b, clr_b;
  logic [5:0]  rs_b;
  logic        busy_b;

  logic        tgt, cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] addr, wdata;

  assign bus_a.i_wb_cyc  = cyc & ~tgt;
  assign bus_b.i_wb_cyc  = cyc & tgt;
  assign bus_a.i_wb_stb  = stb;
  assign bus_b.i_wb_stb  = stb;
  assign bus_a.i_wb_we   = we;
  assign bus_b.i_wb_we   = we;
  assign bus_a.i_wb_sel  = sel;
  assign bus_b.i_wb_sel  = sel;
  assign bus_a.i_wb_addr = addr;
  assign bus_b.i_wb_addr = addr;
  assign bus_a.i_wb_data = wdata;
  assign bus_b.i_wb_data = wdata;

  wire        ack     = tgt ? bus_b.o_wb_ack  : bus_a.o_wb_ack;
  wire [31:0] rdata   = tgt ? bus_b.o_wb_data : bus_a.o_wb_data;
  wire [79:0] set_s   = tgt ? set_b : {16'b0, set_a};
  wire [79:0] clr_s   = tgt ? clr_b : {16'b0, clr_a};
  wire [5:0]  rs_s    = tgt ? rs_b  : {1'b0, rs_a};

  silife_matrix_wb_bridge #(.WIDTH(64), .HEIGHT(32)) dut_a (
    .clk(clk), .reset(reset), .cells(cells_a), .row_select(rs_a),
    .set_cells(set_a), .clear_cells(clr_a), .busy(busy_a), .wb(bus_a.slave));

  silife_matrix_wb_bridge #(.WIDTH(80), .HEIGHT(33)) dut_b (
    .clk(clk), .reset(reset), .cells(cells_b), .row_select(rs_b),
    .set_cells(set_b), .clear_cells(clr_b), .busy(busy_b), .wb(bus_b.slave));

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  localparam logic [63:0] ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;

  // One Wishbone access with no bulk running: strobes and row_select in the
  // accept cycle, ack one cycle later, read data from the scoreboard.
  task automatic do_access(input logic t, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s,
                           input logic [79:0] es, input logic [79:0] ec,
                           input logic [31:0] er, input logic [5:0] erow,
                           input string nm);
    int n;
    logic [31:0] exp;
    @(negedge clk);
    tgt = t; cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d; sel = s;
    if (!w) exp_q.push_back(er);
    #1;
    checks++;
    if (set_s !== es || clr_s !== ec) begin
      errors++;
      $display("FAIL %s strobes set=%h clear=%h required set=%h clear=%h", nm, set_s, clr_s, es, ec);
    end
    checks++;
    if (rs_s !== erow) begin
      errors++;
      $display("FAIL %s row_select=%0d required %0d", nm, rs_s, erow);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack !== 1'b1 && n < 50);
    checks++;
    if (n != 1 || ack !== 1'b1) begin
      errors++;
      $display("FAIL %s ack_latency=%0d cycles required 1", nm, n);
    end
    if (!a[14]) begin
      checks++;
      if (set_s !== '0 || clr_s !== '0) begin
        errors++;
        $display("FAIL %s strobes_after_accept set=%h clear=%h required 0", nm, set_s, clr_s);
      end
    end
    if (!w) begin
      exp = exp_q.pop_front();
      checks++;
      if (rdata !== exp) begin
        errors++;
        $display("FAIL %s rdata=%h required %h", nm, rdata, exp);
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  // Waits for busy_a to drop; returns cycles spent.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy_a === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; tgt = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    sel = 4'h0; addr = '0; wdata = '0; cells_a = '0; cells_b = '1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus_a.o_wb_ack, bus_b.o_wb_ack, busy_a, busy_b} !== 4'b0 ||
        bus_a.o_wb_data !== '0 || bus_b.o_wb_data !== '0 ||
        set_a !== '0 || clr_a !== '0 || set_b !== '0 || clr_b !== '0) begin
      errors++;
      $display("FAIL reset_state ack=%b%b busy=%b%b data=%h/%h set=%h clear=%h required all 0",
               bus_a.o_wb_ack, bus_b.o_wb_ack, busy_a, busy_b,
               bus_a.o_wb_data, bus_b.o_wb_data, set_a, clr_a);
    end
    reset = 1'b0;
  endtask

  task automatic test_modes();
    cells_a = '0;
    do_access(0, 1, 32'h0000_001C, 32'hA5A5_A5A5, 4'hF,
              {16'b0, 32'hA5A5_A5A5, 32'h0}, {16'b0, 32'h5A5A_5A5A, 32'h0}, '0, 6'd3, "replace");
    @(negedge clk);
    checks++;
    if (ack !== 1'b0) begin
      errors++;
      $display("FAIL ack_single_pulse ack=%b required 0", ack);
    end
    cells_a = 64'h0F;
    do_access(0, 1, 32'h0000_3010, 32'h0000_00FF, 4'h1,
              80'hF0, 80'h0F, '0, 6'd2, "toggle");
    do_access(0, 1, 32'h0000_1000, 32'hFFFF_FFFF, 4'h2,
              80'hFF00, 80'h0, '0, 6'd0, "set_mode");
    do_access(0, 1, 32'h0000_2004, 32'h0000_00F0, 4'hF,
              80'h0, {16'b0, 32'h0000_00F0, 32'h0}, '0, 6'd0, "clear_mode");
  endtask

  task automatic test_read();
    cells_a = 64'h0123_4567_89AB_CDEF;
    do_access(0, 0, 32'h0000_002C, '0, 4'hF, '0, '0, 32'h0123_4567, 6'd5, "read_word1");
    do_access(0, 0, 32'h0000_0028, '0, 4'hF, '0, '0, 32'h89AB_CDEF, 6'd5, "read_word0");
  endtask

  task automatic test_bulk_fill();
    logic [31:0] exp;
    int n;
    cells_a = 64'hDEAD_BEEF_CAFE_F00D;
    do_access(0, 1, 32'h0000_4000, 32'h3, 4'hF, '0, '0, '0, 6'd0, "ctrl_fill");
    for (int k = 0; k < 32; k++) begin
      if (k == 3) begin
        tgt = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h0000_0008;
        exp_q.push_back(32'hCAFE_F00D);
      end
      #1;
      checks++;
      if (busy_a !== 1'b1 || rs_a !== 5'(k) || set_a !== ONES64 || clr_a !== '0 ||
          (k > 0 && ack !== 1'b0)) begin
        errors++;
        $display("FAIL fill_row%0d busy=%b row=%0d set=%h clear=%h ack=%b required busy=1 row=%0d set=ones clear=0 ack=0",
                 k, busy_a, rs_a, set_a, clr_a, ack, k);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (busy_a !== 1'b0 || ack !== 1'b0 || set_a !== '0) begin
      errors++;
      $display("FAIL fill_end busy=%b ack=%b set=%h required busy=0 ack=0 set=0", busy_a, ack, set_a);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack !== 1'b1 && n < 50);
    exp = exp_q.pop_front();
    checks++;
    if (n != 1 || rdata !== exp) begin
      errors++;
      $display("FAIL stalled_read cycles_after_idle=%0d data=%h required 1 and %h", n, rdata, exp);
    end
    cyc = 1'b0; stb = 1'b0;
    do_access(0, 0, 32'h0000_4000, '0, 4'hF, '0, '0, 32'h0000_0002, 6'd0, "ctrl_read_fill");
    do_access(0, 0, 32'h0000_7FFC, '0, 4'hF, '0, '0, 32'h0000_0002, 6'd31, "ctrl_read_alias");
  endtask

  task automatic test_cancel_and_ignore();
    int n;
    do_access(0, 1, 32'h0000_4000, 32'h1, 4'hF, '0, '0, '0, 6'd0, "ctrl_clear");
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 2) begin
        tgt = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b1;
        addr = 32'h0000_001C; wdata = 32'hFFFF_FFFF; sel = 4'hF;
      end
      if (k == 4) begin cyc = 1'b0; stb = 1'b0; we = 1'b0; end
      if (k == 6) begin
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h0000_4000; wdata = 32'h3;
      end
      #1;
      checks++;
      if (ack !== (k == 7) || set_a !== '0 || clr_a !== ONES64) begin
        errors++;
        $display("FAIL cancel_cycle%0d ack=%b set=%h clear=%h required ack=%b set=0 clear=ones",
                 k, ack, set_a, clr_a, (k == 7));
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    wait_idle(n);
    checks++;
    if (n + 7 != 32 || ack !== 1'b0 || clr_a !== '0) begin
      errors++;
      $display("FAIL clear_duration busy_cycles=%0d ack=%b clear=%h required 32 0 0", n + 7, ack, clr_a);
    end
    do_access(0, 0, 32'h0000_4000, '0, 4'hF, '0, '0, 32'h0000_0000, 6'd0, "ctrl_read_clear");
  endtask

  task automatic test_edges();
    cells_b = '1;
    do_access(1, 0, 32'h0000_000C, '0, 4'hF, '0, '0, 32'h0, 6'd0, "read_word_oor");
    do_access(1, 0, 32'h0000_0018, '0, 4'hF, '0, '0, 32'h0000_FFFF, 6'd1, "read_partial_word");
    do_access(1, 1, 32'h0000_0210, 32'hFFFF_FFFF, 4'hF, '0, '0, '0, 6'd33, "write_row_oor");
    do_access(1, 1, 32'h0000_0208, 32'hFFFF_FFFF, 4'hF,
              {16'hFFFF, 64'h0}, '0, '0, 6'd32, "write_last_row");
  endtask

  task automatic test_reset_abort();
    int n;
    do_access(0, 1, 32'h0000_4000, 32'h1, 4'hF, '0, '0, '0, 6'd0, "ctrl_clear2");
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (rs_a !== 5'd5 || clr_a !== ONES64) begin
      errors++;
      $display("FAIL abort_pre row=%0d clear=%h required 5 ones", rs_a, clr_a);
    end
    reset = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (busy_a !== 1'b0 || ack !== 1'b0 || set_a !== '0 || clr_a !== '0 || rdata !== '0) begin
      errors++;
      $display("FAIL abort_post busy=%b ack=%b set=%h clear=%h data=%h required all 0",
               busy_a, ack, set_a, clr_a, rdata);
    end
    @(negedge clk);
    reset = 1'b0;
    do_access(0, 1, 32'h0000_4000, 32'h3, 4'hF, '0, '0, '0, 6'd0, "ctrl_restart");
    #1;
    checks++;
    if (busy_a !== 1'b1 || rs_a !== 5'd0 || set_a !== ONES64) begin
      errors++;
      $display("FAIL restart busy=%b row=%0d set=%h required 1 0 ones", busy_a, rs_a, set_a);
    end
    wait_idle(n);
    checks++;
    if (n != 32) begin
      errors++;
      $display("FAIL restart_duration busy_cycles=%0d required 32", n);
    end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_read();
    test_bulk_fill();
    test_cancel_and_ignore();
    test_edges();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
